cpu_boot_ctrl: RTL and testbench

Top-level sequencer for the `cpu` core. On a start pulse it loads instruction memory and then data memory from a valid/ready word stream through the external memory ports. It then holds `enable` high for a programmed number of cycles, and finally streams a programmed span of data memory back out over a valid/ready dump port. It sits beside `cpu` in the test/SoC wrapper and is the only driver of the `*_ext`, `*_ext_2` and `enable` inputs of the core.

---
 rtl/cpu_boot_ctrl_pkg.sv | 29 ++
 rtl/cpu_boot_ctrl_if.sv | 51 +++++
 rtl/cpu_boot_ctrl_dump_buffer.sv | 35 +++
 rtl/cpu_boot_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cpu_boot_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_boot_ctrl_pkg.sv
// Shared types and constants for the cpu boot sequencer.
// Covers the state encoding, the memory address strides and the length clamp.
package cpu_boot_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_WAIT,
        S_DUMP_OUT,
        S_DONE
    } state_e;

    localparam int IMEM_STRIDE = 4;
    localparam int DMEM_STRIDE = 8;
    localparam int LEN_W       = 11;

    // A requested length larger than the memory is cut down to the memory depth.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int              depth);
        if (int'(len) > depth) begin
            return LEN_W'(depth);
        end
        return len;
    endfunction

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Bundle of control, load-stream, dump-stream and cpu memory-port signals.
// The master modport is the sequencer; the slave modport is its environment.
interface cpu_boot_ctrl_if #(
    parameter int CYC_W = 32
);
    logic             start;
    logic [9:0]       imem_len;
    logic [10:0]      dmem_len;
    logic [CYC_W-1:0] run_cycles;

    logic             ld_valid;
    logic [63:0]      ld_data;
    logic             ld_ready;

    logic             dump_valid;
    logic [63:0]      dump_data;
    logic             dump_ready;

    logic             enable;
    logic [63:0]      addr_ext;
    logic             wen_ext;
    logic             ren_ext;
    logic [31:0]      wdata_ext;
    logic [63:0]      addr_ext_2;
    logic             wen_ext_2;
    logic             ren_ext_2;
    logic [63:0]      wdata_ext_2;
    logic [63:0]      rdata_ext_2;

    logic             busy;
    logic             done;

    modport master (
        input  start, imem_len, dmem_len, run_cycles,
        input  ld_valid, ld_data, dump_ready, rdata_ext_2,
        output ld_ready, dump_valid, dump_data, enable,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
        output busy, done
    );

    modport slave (
        output start, imem_len, dmem_len, run_cycles,
        output ld_valid, ld_data, dump_ready, rdata_ext_2,
        input  ld_ready, dump_valid, dump_data, enable,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
        input  busy, done
    );

endinterface

// File: rtl/cpu_boot_ctrl_dump_buffer.sv
// One-entry output register for the dump stream.
// The word is held stable from capture until the consumer takes it.
module dump_buffer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (load_i) begin
                valid_q <= 1'b1;
                data_q  <= data_i;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot sequencer beside the cpu core: load imem then dmem from a word stream,
// run the core for a programmed number of cycles, then dump a span of dmem.
module cpu_boot_ctrl
    import cpu_boot_ctrl_pkg::*;
#(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024,
    parameter int CYC_W      = 32
) (
    input  logic            clk,
    input  logic            arst_n,
    cpu_boot_ctrl_if.master bus
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   imemLen_q, imemLen_d;
    logic [LEN_W-1:0]   dmemLen_q, dmemLen_d;
    logic [LEN_W-1:0]   startILen, startDLen;
    logic [CYC_W-1:0]   runCyc_q, runCyc_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               enable_q, enable_d;
    logic               bufLoad;
    logic               dumpValid;
    logic [63:0]        dumpData;
    logic               dumpFire;

    assign startILen = clamp_len({1'b0, bus.imem_len}, IMEM_DEPTH);
    assign startDLen = clamp_len(bus.dmem_len, DMEM_DEPTH);
    assign dumpFire  = dumpValid & bus.dump_ready;

    // A zero run count skips RUN entirely; an empty dump span skips the dump.
    function automatic state_e run_entry(input logic [CYC_W-1:0] cyc,
                                         input logic [LEN_W-1:0] dlen);
        if (cyc != '0) begin
            return S_RUN;
        end else if (dlen != '0) begin
            return S_DUMP_RD;
        end else begin
            return S_DONE;
        end
    endfunction

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        imemLen_d        = imemLen_q;
        dmemLen_d        = dmemLen_q;
        runCyc_d         = runCyc_q;
        cyc_d            = cyc_q;
        enable_d         = 1'b0;
        bufLoad          = 1'b0;
        bus.ld_ready     = 1'b0;
        bus.wen_ext      = 1'b0;
        bus.addr_ext     = '0;
        bus.wdata_ext    = '0;
        bus.wen_ext_2    = 1'b0;
        bus.ren_ext_2    = 1'b0;
        bus.addr_ext_2   = '0;
        bus.wdata_ext_2  = '0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    imemLen_d = startILen;
                    dmemLen_d = startDLen;
                    runCyc_d  = bus.run_cycles;
                    idx_d     = '0;
                    if (startILen != '0) begin
                        state_d = S_LOAD_I;
                    end else if (startDLen != '0) begin
                        state_d = S_LOAD_D;
                    end else begin
                        state_d  = run_entry(bus.run_cycles, startDLen);
                        cyc_d    = bus.run_cycles;
                        enable_d = (state_d == S_RUN);
                    end
                end
            end

            S_LOAD_I: begin
                bus.ld_ready  = 1'b1;
                bus.wen_ext   = bus.ld_valid;
                bus.addr_ext  = 64'(idx_q) * 64'(IMEM_STRIDE);
                bus.wdata_ext = bus.ld_data[31:0];
                if (bus.ld_valid) begin
                    if (idx_q == imemLen_q - LEN_W'(1)) begin
                        idx_d = '0;
                        if (dmemLen_q != '0) begin
                            state_d = S_LOAD_D;
                        end else begin
                            state_d  = run_entry(runCyc_q, dmemLen_q);
                            cyc_d    = runCyc_q;
                            enable_d = (state_d == S_RUN);
                        end
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end

            S_LOAD_D: begin
                bus.ld_ready    = 1'b1;
                bus.wen_ext_2   = bus.ld_valid;
                bus.addr_ext_2  = 64'(idx_q) * 64'(DMEM_STRIDE);
                bus.wdata_ext_2 = bus.ld_data;
                if (bus.ld_valid) begin
                    if (idx_q == dmemLen_q - LEN_W'(1)) begin
                        idx_d    = '0;
                        state_d  = run_entry(runCyc_q, dmemLen_q);
                        cyc_d    = runCyc_q;
                        enable_d = (state_d == S_RUN);
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end

            // cyc_q counts the enable-high cycles still owed, including this one.
            S_RUN: begin
                if (cyc_q <= CYC_W'(1)) begin
                    idx_d   = '0;
                    state_d = (dmemLen_q != '0) ? S_DUMP_RD : S_DONE;
                end else begin
                    cyc_d    = cyc_q - CYC_W'(1);
                    enable_d = 1'b1;
                end
            end

            S_DUMP_RD: begin
                bus.ren_ext_2  = 1'b1;
                bus.addr_ext_2 = 64'(idx_q) * 64'(DMEM_STRIDE);
                state_d        = S_DUMP_WAIT;
            end

            S_DUMP_WAIT: begin
                bufLoad = 1'b1;
                state_d = S_DUMP_OUT;
            end

            S_DUMP_OUT: begin
                if (dumpFire) begin
                    if (idx_q == dmemLen_q - LEN_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + LEN_W'(1);
                        state_d = S_DUMP_RD;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            imemLen_q <= '0;
            dmemLen_q <= '0;
            runCyc_q  <= '0;
            cyc_q     <= '0;
            enable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            imemLen_q <= imemLen_d;
            dmemLen_q <= dmemLen_d;
            runCyc_q  <= runCyc_d;
            cyc_q     <= cyc_d;
            enable_q  <= enable_d;
        end
    end

    dump_buffer #(.W(64)) u_dump_buffer (
        .clk     (clk),
        .arst_n  (arst_n),
        .load_i  (bufLoad),
        .data_i  (bus.rdata_ext_2),
        .ready_i (bus.dump_ready),
        .valid_o (dumpValid),
        .data_o  (dumpData)
    );

    assign bus.enable     = enable_q;
    assign bus.ren_ext    = 1'b0;
    assign bus.dump_valid = dumpValid;
    assign bus.dump_data  = dumpData;
    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done       = (state_q == S_DONE);

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Scoreboard bench for cpu_boot_ctrl: stimulus queues the expected memory and
// dump events, a negedge monitor pops and compares them as the DUT emits them.
module tb_cpu_boot_ctrl;

    localparam int K_IW  = 0;
    localparam int K_DW  = 1;
    localparam int K_RD  = 2;
    localparam int K_OUT = 3;
    localparam int K_EN  = 4;

    typedef struct {
        int          kind;
        logic [63:0] addr;
        logic [63:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        arst_n;
    ev_t         expQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    bit          toggleReady = 1'b0;
    int          runLen = 0;
    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    logic [63:0] prevData = '0;
    logic [63:0] lastImemAddr = '0;
    logic [63:0] dmemModel [0:1023];

    always #5 clk = ~clk;

    cpu_boot_ctrl_if #(.CYC_W(32)) bus ();

    cpu_boot_ctrl #(
        .IMEM_DEPTH (512),
        .DMEM_DEPTH (1024),
        .CYC_W      (32)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    // Behavioural data memory with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.wen_ext_2) dmemModel[bus.addr_ext_2[12:3]] <= bus.wdata_ext_2;
        if (bus.ren_ext_2) bus.rdata_ext_2 <= dmemModel[bus.addr_ext_2[12:3]];
    end

    always @(posedge clk) begin
        #1;
        if (toggleReady) bus.dump_ready = ~bus.dump_ready;
        else             bus.dump_ready = 1'b1;
    end

    function automatic string kindName(input int k);
        case (k)
            K_IW:    return "imem_write";
            K_DW:    return "dmem_write";
            K_RD:    return "dmem_read";
            K_OUT:   return "dump_word";
            default: return "enable_run";
        endcase
    endfunction

    function automatic logic [31:0] imemLo(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    function automatic logic [63:0] imemWord(input int i);
        return {32'hFFFF_EEEE, imemLo(i)};
    endfunction

    function automatic logic [63:0] dmemWord(input int i);
        return 64'hD00D_0000_0000_0000 | 64'(i);
    endfunction

    task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic checkOutput(input int kind, input logic [63:0] addr, input logic [63:0] data);
        ev_t e;
        testsRun++;
        if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL unexpected %s: got addr=%h data=%h, expected no event",
                     kindName(kind), addr, data);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.addr !== addr || e.data !== data) begin
                testsFailed++;
                $display("[TB] FAIL %s: got %s addr=%h data=%h, expected %s addr=%h data=%h",
                         kindName(e.kind), kindName(kind), addr, data,
                         kindName(e.kind), e.addr, e.data);
            end
        end
    endtask

    // Enable is handled first so a run that ends as the first dump read starts
    // is reported in program order.
    always @(negedge clk) begin
        if (!arst_n) begin
            runLen    = 0;
            prevValid = 1'b0;
        end else begin
            if (bus.enable) begin
                runLen++;
            end else if (runLen > 0) begin
                checkOutput(K_EN, 64'd0, 64'(runLen));
                runLen = 0;
            end
            if (bus.wen_ext) begin
                checkOutput(K_IW, bus.addr_ext, {32'b0, bus.wdata_ext});
                lastImemAddr = bus.addr_ext;
            end
            if (bus.wen_ext_2) checkOutput(K_DW, bus.addr_ext_2, bus.wdata_ext_2);
            if (bus.ren_ext_2) checkOutput(K_RD, bus.addr_ext_2, 64'd0);
            if (bus.dump_valid && bus.dump_ready) checkOutput(K_OUT, 64'd0, bus.dump_data);
            if (prevValid && !prevReady && bus.dump_valid)
                checkVal("dump_data stable", bus.dump_data, prevData);
            prevValid = bus.dump_valid;
            prevReady = bus.dump_ready;
            prevData  = bus.dump_data;
        end
    end

    task automatic loadWords(input int nI, input int nD, input bit gap);
        int  total = nI + nD;
        int  w = 0;
        int  cyc = 0;
        bit  accepted;
        while (w < total && cyc < 5000) begin
            accepted = 1'b0;
            if (gap && (cyc % 3 != 0)) begin
                bus.ld_valid = 1'b0;
                checkVal("ld_ready on idle cycle", {63'b0, bus.ld_ready}, 64'd1);
            end else begin
                bus.ld_valid = 1'b1;
                bus.ld_data  = (w < nI) ? imemWord(w) : dmemWord(w - nI);
                accepted     = bus.ld_ready;
            end
            @(posedge clk);
            #1;
            if (accepted) w++;
            cyc++;
        end
        bus.ld_valid = 1'b0;
        if (w < total) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL load stream: got %0d words accepted, expected %0d", w, total);
        end
    endtask

    task automatic applyStimulus(input int iLen, input int dLen, input int run,
                                 input int expI, input int expD,
                                 input bit gap, input bit toggle, input bit full);
        toggleReady = toggle;
        for (int i = 0; i < expI; i++)
            expQ.push_back('{kind: K_IW, addr: 64'(i * 4), data: {32'b0, imemLo(i)}});
        for (int i = 0; i < expD; i++)
            expQ.push_back('{kind: K_DW, addr: 64'(i * 8), data: dmemWord(i)});
        if (full) begin
            if (run > 0) expQ.push_back('{kind: K_EN, addr: 64'd0, data: 64'(run)});
            for (int i = 0; i < expD; i++) begin
                expQ.push_back('{kind: K_RD, addr: 64'(i * 8), data: 64'd0});
                expQ.push_back('{kind: K_OUT, addr: 64'd0, data: dmemWord(i)});
            end
        end
        @(posedge clk);
        #1;
        bus.imem_len   = 10'(iLen);
        bus.dmem_len   = 11'(dLen);
        bus.run_cycles = 32'(run);
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        loadWords(expI, expD, gap);
    endtask

    task automatic waitDone(input int bound);
        int n = 0;
        while (!bus.done && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL done timeout: got done=0 after %0d cycles, expected done=1", n);
        end
        @(posedge clk);
        #1;
        checkVal("scoreboard drained", 64'(expQ.size()), 64'd0);
        checkVal("done high", {63'b0, bus.done}, 64'd1);
        checkVal("busy low", {63'b0, bus.busy}, 64'd0);
        expQ.delete();
        repeat (3) @(posedge clk);
        #1;
        checkVal("done holds", {63'b0, bus.done}, 64'd1);
    endtask

    initial begin
        int n;
        arst_n         = 1'b0;
        bus.start      = 1'b0;
        bus.imem_len   = '0;
        bus.dmem_len   = '0;
        bus.run_cycles = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        #12;
        checkVal("reset enable", {63'b0, bus.enable}, 64'd0);
        checkVal("reset busy", {63'b0, bus.busy}, 64'd0);
        checkVal("reset done", {63'b0, bus.done}, 64'd0);
        checkVal("reset strobes", {60'b0, bus.ld_ready, bus.wen_ext, bus.wen_ext_2, bus.ren_ext_2}, 64'd0);
        checkVal("reset dump_valid", {63'b0, bus.dump_valid}, 64'd0);
        checkVal("reset dump_data", bus.dump_data, 64'd0);
        checkVal("reset addr_ext", bus.addr_ext, 64'd0);
        checkVal("reset addr_ext_2", bus.addr_ext_2, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;

        $display("[TB] streaming load 3/2, run 4");
        applyStimulus(3, 2, 4, 3, 2, 1'b0, 1'b0, 1'b1);
        waitDone(200);

        $display("[TB] gapped load 3/2, run 3");
        applyStimulus(3, 2, 3, 3, 2, 1'b1, 1'b0, 1'b1);
        waitDone(200);

        $display("[TB] dump of 4 words with toggling dump_ready");
        applyStimulus(2, 4, 2, 2, 4, 1'b0, 1'b1, 1'b1);
        waitDone(200);

        $display("[TB] empty loads, run 5");
        applyStimulus(0, 0, 5, 0, 0, 1'b0, 1'b0, 1'b1);
        waitDone(100);

        $display("[TB] imem_len 600 clamped to 512");
        applyStimulus(600, 1, 2, 512, 1, 1'b0, 1'b0, 1'b1);
        waitDone(200);
        checkVal("last addr_ext", lastImemAddr, 64'd2044);

        $display("[TB] reset during run");
        applyStimulus(1, 1, 20, 1, 1, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!bus.enable && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkVal("enable reached", {63'b0, bus.enable}, 64'd1);
        repeat (3) @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        checkVal("enable drops on reset", {63'b0, bus.enable}, 64'd0);
        checkVal("idle after reset", {62'b0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        #1;
        arst_n = 1'b1;
        checkVal("scoreboard before replay", 64'(expQ.size()), 64'd0);
        applyStimulus(1, 1, 3, 1, 1, 1'b0, 1'b0, 1'b1);
        waitDone(200);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
